// File: rtl/rhd_spi_responder.sv
// RHD2000-style SPI slave (one MISO lane): decodes 16-bit command frames and answers two frames later.
// Latency: a CS/SCLK pin edge reaches MISO SYNC_STAGES+1 clk later; results appear on MISO two frames after their command.
// No backpressure: the SPI master owns timing; short frames are dropped with a frame_err pulse.
// Optional feature: define RHD_RESP_MISO_DELAY_EN to add a miso_delay[3:0] input and a 15-deep MISO delay line.
module rhd_spi_responder #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] CHIP_ID     = 8'd1,
  parameter logic [7:0] NUM_AMPS    = 8'd32
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        CS,
  input  logic        SCLK,
  input  logic        MOSI,
`ifdef RHD_RESP_MISO_DELAY_EN
  input  logic [3:0]  miso_delay,
`endif
  output logic        MISO,
  output logic        cmd_valid,
  output logic [15:0] cmd_word,
  output logic        frame_err,
  output logic [9:0]  conv_cnt
);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_DONE} state_t;

  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_cs_d;
  logic                   r_sclk_d;

  state_t      r_state;
  logic [4:0]  r_bit_cnt;
  logic [15:0] r_rx_sr;
  logic [14:0] r_tx_sr;
  logic        r_miso;
  logic        r_cmd_vld;
  logic [15:0] r_cmd_word;
  logic        r_frame_err;
  logic [9:0]  r_conv_cnt;
  logic [15:0] r_r1;
  logic [15:0] r_r2;
  logic [7:0]  r_regs [0:17];

  logic        w_cs;
  logic        w_sclk;
  logic        w_mosi;
  logic        w_cs_fall;
  logic        w_cs_rise;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic [5:0]  w_addr;
  logic [7:0]  w_data;
  logic [7:0]  w_rd_val;
  logic [15:0] w_result;
  logic        w_is_conv;
  logic        w_is_clear;
  logic        w_is_write;

  assign w_cs   = r_cs_sync[SYNC_STAGES-1];
  assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

  assign w_cs_fall   = r_cs_d & ~w_cs;
  assign w_cs_rise   = ~r_cs_d & w_cs;
  assign w_sclk_rise = ~r_sclk_d & w_sclk;
  assign w_sclk_fall = r_sclk_d & ~w_sclk;

  assign w_addr = r_rx_sr[13:8];
  assign w_data = r_rx_sr[7:0];

  // Synchronise pins and keep last synced CS/SCLK for edge detection.
  // CS chain resets low so a CS already low when reset releases is not mistaken for a fresh fall.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cs_sync   <= '0;
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_cs_d      <= 1'b0;
      r_sclk_d    <= 1'b0;
    end else begin
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CS};
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_cs_d      <= w_cs;
      r_sclk_d    <= w_sclk;
    end
  end

  // Register-read mux: writable bank, then the read-only ID/ROM area.
  always_comb begin
    w_rd_val = 8'h00;
    if (w_addr <= 6'd17) begin
      w_rd_val = r_regs[w_addr[4:0]];
    end else begin
      case (w_addr)
        6'd40:   w_rd_val = 8'h49;
        6'd41:   w_rd_val = 8'h4E;
        6'd42:   w_rd_val = 8'h54;
        6'd43:   w_rd_val = 8'h41;
        6'd44:   w_rd_val = 8'h4E;
        6'd59:   w_rd_val = 8'h53;
        6'd60:   w_rd_val = 8'h01;
        6'd61:   w_rd_val = 8'h01;
        6'd62:   w_rd_val = NUM_AMPS;
        6'd63:   w_rd_val = CHIP_ID;
        default: w_rd_val = 8'h00;
      endcase
    end
  end

  // Command decode; CALIBRATE and every other 01xxxxxx frame simply answer zero.
  always_comb begin
    w_result   = 16'h0000;
    w_is_conv  = 1'b0;
    w_is_clear = 1'b0;
    w_is_write = 1'b0;
    case (r_rx_sr[15:14])
      2'b00: begin
        w_is_conv = 1'b1;
        w_result  = {w_addr, r_conv_cnt};
      end
      2'b01: w_is_clear = (r_rx_sr == 16'h6A00);
      2'b10: begin
        w_is_write = 1'b1;
        w_result   = {8'hFF, w_data};
      end
      default: w_result = {8'h00, w_rd_val};
    endcase
  end

  // Frame FSM: shift in on SCLK rise, shift out on SCLK fall, commit the command on CS rise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= 5'd0;
      r_rx_sr     <= 16'h0000;
      r_tx_sr     <= 15'h0000;
      r_miso      <= 1'b0;
      r_cmd_vld   <= 1'b0;
      r_cmd_word  <= 16'h0000;
      r_frame_err <= 1'b0;
      r_conv_cnt  <= 10'd0;
      r_r1        <= 16'h0000;
      r_r2        <= 16'h0000;
      for (int i = 0; i < 18; i++) r_regs[i] <= 8'h00;
    end else begin
      r_cmd_vld   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_cs_fall) begin
            r_tx_sr   <= r_r2[14:0];
            r_miso    <= r_r2[15];
            r_bit_cnt <= 5'd0;
            r_state   <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (w_cs_rise) begin
            if (r_bit_cnt == 5'd16) begin
              r_r2       <= r_r1;
              r_r1       <= w_result;
              r_cmd_vld  <= 1'b1;
              r_cmd_word <= r_rx_sr;
              if (w_is_conv)  r_conv_cnt <= r_conv_cnt + 10'd1;
              if (w_is_clear) r_conv_cnt <= 10'd0;
              if (w_is_write && (w_addr <= 6'd17)) r_regs[w_addr[4:0]] <= w_data;
            end else begin
              r_frame_err <= 1'b1;
            end
            r_state <= ST_DONE;
          end else begin
            if (w_sclk_rise) begin
              r_rx_sr <= {r_rx_sr[14:0], w_mosi};
              if (r_bit_cnt != 5'd16) r_bit_cnt <= r_bit_cnt + 5'd1;
            end
            // MISO advances only between bits; after the last bit it holds.
            if (w_sclk_fall && (r_bit_cnt >= 5'd1) && (r_bit_cnt <= 5'd15)) begin
              r_miso  <= r_tx_sr[14];
              r_tx_sr <= {r_tx_sr[13:0], 1'b0};
            end
          end
        end
        default: begin
          // DONE lasts one clk, so a CS fall seen here starts the next frame directly.
          if (w_cs_fall) begin
            r_tx_sr   <= r_r2[14:0];
            r_miso    <= r_r2[15];
            r_bit_cnt <= 5'd0;
            r_state   <= ST_SHIFT;
          end else begin
            r_miso  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

`ifdef RHD_RESP_MISO_DELAY_EN
  logic [14:0] r_miso_line;

  // Board/cable delay model: tap 0 is the undelayed MISO register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_miso_line <= 15'h0000;
    else       r_miso_line <= {r_miso_line[13:0], r_miso};
  end

  assign MISO = (miso_delay == 4'd0) ? r_miso : r_miso_line[miso_delay - 4'd1];
`else
  assign MISO = r_miso;
`endif

  assign cmd_valid = r_cmd_vld;
  assign cmd_word  = r_cmd_word;
  assign frame_err = r_frame_err;
  assign conv_cnt  = r_conv_cnt;

endmodule

// File: tb/tb_rhd_spi_responder.sv
// Scoreboard bench for rhd_spi_responder: drives SPI frames, predicts each result two frames ahead.
module tb_rhd_spi_responder;

  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        CS = 1'b1;
  logic        SCLK = 1'b0;
  logic        MOSI = 1'b0;
  logic        MISO;
  logic        cmd_valid;
  logic [15:0] cmd_word;
  logic        frame_err;
  logic [9:0]  conv_cnt;
`ifdef RHD_RESP_MISO_DELAY_EN
  logic [3:0]  miso_delay = 4'd0;
`endif

  int checks = 0;
  int failures = 0;
  int g_lat = -1;

  logic [15:0] exp_q [$];
  logic [7:0]  m_regs [0:17];
  logic [9:0]  m_conv;

  always #5 clk = ~clk;

  rhd_spi_responder dut (
    .clk       (clk),
    .rstn      (rstn),
    .CS        (CS),
    .SCLK      (SCLK),
    .MOSI      (MOSI),
`ifdef RHD_RESP_MISO_DELAY_EN
    .miso_delay(miso_delay),
`endif
    .MISO      (MISO),
    .cmd_valid (cmd_valid),
    .cmd_word  (cmd_word),
    .frame_err (frame_err),
    .conv_cnt  (conv_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rom_rd(input logic [5:0] a);
    case (a)
      6'd40: return 8'h49;
      6'd41: return 8'h4E;
      6'd42: return 8'h54;
      6'd43: return 8'h41;
      6'd44: return 8'h4E;
      6'd59: return 8'h53;
      6'd60: return 8'h01;
      6'd61: return 8'h01;
      6'd62: return 8'h20;
      6'd63: return 8'h01;
      default: return 8'h00;
    endcase
  endfunction

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back(16'h0000);
    exp_q.push_back(16'h0000);
    for (int i = 0; i < 18; i++) m_regs[i] = 8'h00;
    m_conv = 10'd0;
  endtask

  task automatic model_cmd(input logic [15:0] c);
    logic [15:0] res;
    logic [5:0]  a;
    a = c[13:8];
    res = 16'h0000;
    case (c[15:14])
      2'b00: begin
        res = {a, m_conv};
        m_conv = m_conv + 10'd1;
      end
      2'b01: if (c == 16'h6A00) m_conv = 10'd0;
      2'b10: begin
        if (a <= 6'd17) m_regs[a] = c[7:0];
        res = {8'hFF, c[7:0]};
      end
      default: res = {8'h00, (a <= 6'd17) ? m_regs[a] : rom_rd(a)};
    endcase
    exp_q.push_back(res);
  endtask

  // One SPI frame of nbits; rst_at >= 0 pulses rstn right after that bit's SCLK rise.
  task automatic spi_frame(input logic [15:0] cmd, input int nbits, input int rst_at);
    logic [15:0] got;
    logic [15:0] cw;
    logic [15:0] exp;
    int vld_n;
    int err_n;
    bit aborted;
    got = 16'h0000;
    cw = 16'h0000;
    aborted = 1'b0;
    g_lat = -1;
    @(negedge clk) CS = 1'b0;
    if (nbits == 0) repeat (HALF) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      MOSI = cmd[15-b];
      for (int k = 0; k < HALF; k++) begin
        @(negedge clk);
        if (b == 0 && g_lat < 0 && MISO === 1'b1) g_lat = k + 1;
      end
      got[15-b] = MISO;
      SCLK = 1'b1;
      if (b == rst_at) begin
        rstn = 1'b0;
        @(negedge clk);
        chk("rst_miso", {31'd0, MISO}, 32'd0);
        chk("rst_conv", {22'd0, conv_cnt}, 32'd0);
        chk("rst_cmd_word", {16'd0, cmd_word}, 32'd0);
        rstn = 1'b1;
        aborted = 1'b1;
      end
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
    end
    repeat (HALF) @(negedge clk);
    CS = 1'b1;
    vld_n = 0;
    err_n = 0;
    repeat (8) begin
      @(negedge clk);
      if (cmd_valid) begin
        vld_n++;
        cw = cmd_word;
      end
      if (frame_err) err_n++;
    end
    repeat (2) @(negedge clk);
    if (aborted) begin
      chk("abort_vld", vld_n, 0);
      chk("abort_err", err_n, 0);
      model_reset();
    end else if (nbits == 16) begin
      chk("cmd_valid_pulse", vld_n, 1);
      chk("no_frame_err", err_n, 0);
      chk("cmd_word", {16'd0, cw}, {16'd0, cmd});
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 1, 0);
      end else begin
        exp = exp_q.pop_front();
        chk("miso_frame", {16'd0, got}, {16'd0, exp});
      end
      model_cmd(cmd);
    end else begin
      chk("short_no_vld", vld_n, 0);
      chk("short_err_pulse", err_n, 1);
    end
  endtask

  initial begin
    model_reset();
    repeat (4) @(negedge clk);
    chk("reset_miso", {31'd0, MISO}, 32'd0);
    chk("reset_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    chk("reset_cmd_word", {16'd0, cmd_word}, 32'd0);
    chk("reset_frame_err", {31'd0, frame_err}, 32'd0);
    chk("reset_conv_cnt", {22'd0, conv_cnt}, 32'd0);
    rstn = 1'b1;
    repeat (6) @(negedge clk);

    // ROM reads: CHIP_ID, NUM_AMPS, "I", then two dummies
    spi_frame(16'hFF00, 16, -1);
    spi_frame(16'hFE00, 16, -1);
    spi_frame(16'hE800, 16, -1);
    spi_frame(16'hC000, 16, -1);
    spi_frame(16'hC000, 16, -1);

    // write reg 5 then read it back
    spi_frame(16'h8585, 16, -1);
    spi_frame(16'hC500, 16, -1);
    spi_frame(16'hC000, 16, -1);
    spi_frame(16'hC000, 16, -1);

    // SCLK toggling with CS high must not disturb anything
    repeat (5) begin
      @(negedge clk) SCLK = 1'b1;
      repeat (HALF) @(negedge clk);
      SCLK = 1'b0;
      repeat (HALF) @(negedge clk);
    end

    // two rounds of CONVERT over ch 0..34, then CLEAR
    for (int r = 0; r < 2; r++)
      for (int ch = 0; ch < 35; ch++)
        spi_frame({2'b00, 6'(ch), 8'h00}, 16, -1);
    chk("conv_cnt_after_70", {22'd0, conv_cnt}, {22'd0, m_conv});
    spi_frame(16'h5500, 16, -1);
    spi_frame(16'h6A00, 16, -1);
    spi_frame(16'h0300, 16, -1);
    spi_frame(16'hC000, 16, -1);
    spi_frame(16'hC000, 16, -1);
    chk("conv_cnt_after_clear", {22'd0, conv_cnt}, 32'd1);

    // short frames: 9 bits, and CS low with no SCLK at all
    spi_frame(16'hFF00, 9, -1);
    spi_frame(16'hFF00, 0, -1);
    spi_frame(16'hFF00, 16, -1);
    spi_frame(16'hC000, 16, -1);
    spi_frame(16'hC000, 16, -1);

    // reset mid-frame clears registers and pipe
    spi_frame(16'h8585, 16, -1);
    spi_frame(16'hC500, 16, 7);
    spi_frame(16'hC500, 16, -1);
    spi_frame(16'hC000, 16, -1);
    spi_frame(16'hC000, 16, -1);

`ifdef RHD_RESP_MISO_DELAY_EN
    begin
      int lat0;
      int lat3;
      spi_frame(16'h8101, 16, -1);
      spi_frame(16'hC000, 16, -1);
      spi_frame(16'hC000, 16, -1);
      lat0 = g_lat;
      spi_frame(16'h8102, 16, -1);
      spi_frame(16'hC000, 16, -1);
      miso_delay = 4'd3;
      spi_frame(16'hC000, 16, -1);
      lat3 = g_lat;
      miso_delay = 4'd0;
      chk("lat0_seen", {31'd0, lat0 > 0}, 32'd1);
      chk("delay3_shift", lat3 - lat0, 3);
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
